// File: rtl/pong_input_pkg.sv
// Shared constants and helpers for the pong input-conditioning stage.
// Optional feature macro: AUTOREPEAT_EN (see debounce_channel / pong_input_conditioner).
package pong_input_pkg;

    // Defaults for a 25 MHz pixel clock and a 1 ms debounce tick.
    localparam int unsigned DEFAULT_NUM_BTN      = 6;
    localparam int unsigned DEFAULT_TICK_DIV     = 25000;
    localparam int unsigned DEFAULT_STABLE_TICKS = 10;
    localparam int unsigned DEFAULT_SYNC_STAGES  = 2;
    localparam int unsigned DEFAULT_REPEAT_DELAY = 400;
    localparam int unsigned DEFAULT_REPEAT_RATE  = 100;

    // Bit positions of the buttons on btn_raw.
    typedef enum int unsigned {
        BTN_P0    = 0,
        BTN_P1    = 1,
        BTN_P2    = 2,
        BTN_P3    = 3,
        BTN_RST   = 4,
        BTN_SERVE = 5
    } btn_idx_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, tick-based debouncer, press/release pulses.
// With AUTOREPEAT_EN defined, a held button also emits periodic press pulses.
module debounce_channel
    import pong_input_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int unsigned SYNC_STAGES  = DEFAULT_SYNC_STAGES
`ifdef AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEFAULT_REPEAT_RATE
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned    CntW    = cnt_width(STABLE_TICKS);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_sync;
    logic                   state_q, state_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   accept;
    logic                   rep_fire;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Shift the raw pin into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw_i};
    end

    // Debounce: any cycle matching the current level discards progress.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = 1'b0;
        if (btn_sync == state_q) begin
            count_d = '0;
        end else if (tick_i) begin
            if (count_q == CntLast) begin
                accept  = 1'b1;
                state_d = btn_sync;
                count_d = '0;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned RepW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                                           : REPEAT_RATE);
    localparam logic [RepW-1:0] RepDelayLast = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepRateLast  = RepW'(REPEAT_RATE - 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_armed_q, rep_armed_d;

    // Count ticks while held; first pulse after the delay, then at the rate.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (accept || !state_q) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (tick_i) begin
            if (rep_cnt_q == (rep_armed_q ? RepRateLast : RepDelayLast)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + RepW'(1);
            end
        end
    end

    // Repeat counter state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Pulses: the new level decides press vs release, so both can never coincide.
    always_comb begin
        press_d   = (accept & btn_sync) | rep_fire;
        release_d = accept & ~btn_sync;
    end

    // Channel state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            state_q   <= 1'b0;
            count_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            count_q   <= count_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/pong_input_conditioner.sv
// Top of the input-conditioning stage: shared debounce-tick prescaler plus one
// debounce_channel per button. Optional feature macro: AUTOREPEAT_EN.
module pong_input_conditioner
    import pong_input_pkg::*;
#(
    parameter int unsigned NUM_BTN      = DEFAULT_NUM_BTN,
    parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int unsigned SYNC_STAGES  = DEFAULT_SYNC_STAGES,
    parameter int unsigned REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               tick
);

    // Reject configurations the datapath cannot represent.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2");
    end
    if (STABLE_TICKS < 1) begin : g_bad_stable
        $error("STABLE_TICKS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    localparam int unsigned     DivW    = cnt_width(TICK_DIV - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            tick_q, tick_d;

    // Free-running prescaler; tick is registered so it lands one cycle after the wrap value.
    always_comb begin
        tick_d = (div_q == DivLast);
        div_d  = tick_d ? '0 : div_q + DivW'(1);
    end

    // Prescaler registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef AUTOREPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
`endif
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .tick_i   (tick_q),
            .btn_raw_i(btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i])
        );
    end

endmodule
